// File: rtl/seq_pkg.sv
// Shared definitions for the tempo/step sequencer: step-order modes,
// the power-on tempo period and direction encodings.
package seq_pkg;

  // Step traversal order selected by the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_FWD  = 2'd0,
    MODE_REV  = 2'd1,
    MODE_PP   = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  // Clocks per step after power-on, until software writes a period.
  localparam int unsigned DEF_PERIOD = 5000000;

  // Traversal direction as reported on the dir output.
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tempo_divider.sv
// Tempo divider: holds the programmable period and counts clocks while
// run is high. terminal is high in the cycle whose rising edge completes
// one period; the counter wraps to zero on that same edge.
module tempo_divider #(
  parameter int          DIV_W      = 26,
  parameter int unsigned DEF_PERIOD = seq_pkg::DEF_PERIOD
) (
  input  logic             clk,
  input  logic             poweron,
  input  logic             run,
  input  logic             restart,
  input  logic             period_wr,
  input  logic [DIV_W-1:0] period_in,
  output logic             terminal
);

  // A zero period would never terminate, so it is promoted to one.
  localparam logic [DIV_W-1:0] PERIOD_RST =
    (DEF_PERIOD == 0) ? DIV_W'(1) : DIV_W'(DEF_PERIOD);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] div_cnt;
  logic             at_end;

  // Compare with >= so a period written below the running count still
  // terminates on the next run cycle instead of wrapping the counter.
  assign at_end   = (div_cnt >= (period - DIV_W'(1)));
  assign terminal = run & ~restart & at_end;

  // Period register; a written zero is stored as one.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      period <= PERIOD_RST;
    end else if (period_wr) begin
      period <= (period_in == '0) ? DIV_W'(1) : period_in;
    end
  end

  // Clock counter: cleared by restart, advances only while run is high.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      div_cnt <= '0;
    end else if (restart) begin
      div_cnt <= '0;
    end else if (run) begin
      div_cnt <= at_end ? '0 : (div_cnt + DIV_W'(1));
    end
  end

endmodule

// File: rtl/tempo_step_counter.sv
// Tempo-driven step sequencer. A divider produces one advance every
// `period` clocks; each advance moves the step index according to the
// selected mode and pulses step_tick (plus bar_tick when the loop wraps).
module tempo_step_counter #(
  parameter int          STEP_W     = 4,
  parameter int          DIV_W      = 26,
  parameter int unsigned DEF_PERIOD = seq_pkg::DEF_PERIOD
) (
  input  logic              clk,
  input  logic              poweron,
  input  logic              run,
  input  logic              restart,
  input  logic              period_wr,
  input  logic [DIV_W-1:0]  period_in,
  input  logic [STEP_W-1:0] loop_len,
  input  logic [1:0]        mode,
  output logic [STEP_W-1:0] step,
  output logic              step_tick,
  output logic              bar_tick,
  output logic              dir
);

  import seq_pkg::*;

  mode_e             mode_sel;
  logic              advance;
  logic [STEP_W-1:0] nxt_step;
  logic              nxt_dir;
  logic              nxt_bar;

  assign mode_sel = mode_e'(mode);

  tempo_divider #(
    .DIV_W      (DIV_W),
    .DEF_PERIOD (DEF_PERIOD)
  ) u_divider (
    .clk       (clk),
    .poweron   (poweron),
    .run       (run),
    .restart   (restart),
    .period_wr (period_wr),
    .period_in (period_in),
    .terminal  (advance)
  );

  // Position the step index would take on the next advance. Mode is
  // sampled here, so a mode change only shows up at the next advance.
  // HOLD freezes step and dir even for a one-step loop, and never wraps.
  always_comb begin
    nxt_step = step;
    nxt_dir  = dir;
    nxt_bar  = 1'b0;
    if (mode_sel == MODE_HOLD) begin
      nxt_step = step;
    end else if (loop_len == '0) begin
      nxt_step = '0;
      nxt_bar  = 1'b1;
      nxt_dir  = (mode_sel == MODE_REV) ? DIR_DOWN : DIR_UP;
    end else begin
      case (mode_sel)
        MODE_FWD: begin
          nxt_dir = DIR_UP;
          if (step >= loop_len) begin
            nxt_step = '0;
            nxt_bar  = 1'b1;
          end else begin
            nxt_step = step + STEP_W'(1);
          end
        end
        MODE_REV: begin
          nxt_dir = DIR_DOWN;
          if ((step == '0) || (step > loop_len)) begin
            nxt_step = loop_len;
            nxt_bar  = 1'b1;
          end else begin
            nxt_step = step - STEP_W'(1);
          end
        end
        MODE_PP: begin
          if (step > loop_len) begin
            nxt_step = '0;
            nxt_dir  = DIR_UP;
            nxt_bar  = 1'b1;
          end else if (dir == DIR_UP) begin
            if (step == loop_len) begin
              nxt_step = loop_len - STEP_W'(1);
              nxt_dir  = DIR_DOWN;
            end else begin
              nxt_step = step + STEP_W'(1);
            end
          end else begin
            if (step == '0) begin
              nxt_step = STEP_W'(1);
              nxt_dir  = DIR_UP;
              nxt_bar  = 1'b1;
            end else begin
              nxt_step = step - STEP_W'(1);
            end
          end
        end
        default: begin
          nxt_step = step;
        end
      endcase
    end
  end

  // Step/dir state and registered tick pulses; restart wins over advance.
  always_ff @(posedge clk or negedge poweron) begin
    if (!poweron) begin
      step      <= '0;
      dir       <= DIR_UP;
      step_tick <= 1'b0;
      bar_tick  <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      bar_tick  <= 1'b0;
      if (restart) begin
        if (mode_sel == MODE_REV) begin
          step <= loop_len;
          dir  <= DIR_DOWN;
        end else begin
          step <= '0;
          dir  <= DIR_UP;
        end
      end else if (advance) begin
        step      <= nxt_step;
        dir       <= nxt_dir;
        step_tick <= 1'b1;
        bar_tick  <= nxt_bar;
      end
    end
  end

endmodule

// File: tb/tb_tempo_step_counter.sv
// Scoreboard bench for tempo_step_counter: a behavioural model predicts
// every advance (cycle, step, dir, bar) and a negedge monitor checks them.
module tb_tempo_step_counter;

  localparam int STEP_W = 4;
  localparam int DIV_W  = 8;
  localparam int DEF_P  = 5;

  logic              clk = 1'b0;
  logic              poweron;
  logic              run;
  logic              restart;
  logic              period_wr;
  logic [DIV_W-1:0]  period_in;
  logic [STEP_W-1:0] loop_len;
  logic [1:0]        mode;
  logic [STEP_W-1:0] step;
  logic              step_tick;
  logic              bar_tick;
  logic              dir;

  tempo_step_counter #(
    .STEP_W     (STEP_W),
    .DIV_W      (DIV_W),
    .DEF_PERIOD (DEF_P)
  ) dut (
    .clk       (clk),
    .poweron   (poweron),
    .run       (run),
    .restart   (restart),
    .period_wr (period_wr),
    .period_in (period_in),
    .loop_len  (loop_len),
    .mode      (mode),
    .step      (step),
    .step_tick (step_tick),
    .bar_tick  (bar_tick),
    .dir       (dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int stp;
    int dr;
    int bar;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Model state: clocks into current period, period, position, direction.
  int m_cnt, m_period, m_step, m_dir;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_cnt    = 0;
    m_period = DEF_P;
    m_step   = 0;
    m_dir    = 1;
  endtask

  // Where the step lands on an advance, from the mode rules.
  task automatic next_pos(input int md, input int L, input int s, input int d,
                          output int ns, output int nd, output int nb);
    ns = s; nd = d; nb = 0;
    case (md)
      0: begin
        nd = 1;
        if (s > L) begin ns = 0; nb = 1; end
        else begin ns = (s + 1) % (L + 1); nb = (ns == 0); end
      end
      1: begin
        nd = 0;
        if (s > L) begin ns = L; nb = 1; end
        else begin ns = (s + L) % (L + 1); nb = (s == 0); end
      end
      2: begin
        if (L == 0 || s > L) begin ns = 0; nd = 1; nb = 1; end
        else begin
          int t;
          t = d ? s + 1 : s - 1;
          if (t > L) begin ns = L - 1; nd = 0; end
          else if (t < 0) begin ns = 1; nd = 1; nb = 1; end
          else ns = t;
        end
      end
      default: begin ns = s; nd = d; nb = 0; end
    endcase
  endtask

  // Apply the current inputs to the model for the coming clock edge.
  task automatic model_edge();
    int L, ns, nd, nb;
    bit adv;
    exp_t e;
    L = int'(loop_len);
    adv = 0;
    if (!poweron) begin
      m_reset();
      return;
    end
    if (restart) begin
      m_cnt = 0;
      if (mode == 2'd1) begin m_step = L; m_dir = 0; end
      else begin m_step = 0; m_dir = 1; end
    end else if (run) begin
      if (m_cnt >= m_period - 1) begin m_cnt = 0; adv = 1; end
      else m_cnt++;
    end
    if (period_wr) m_period = (period_in == 0) ? 1 : int'(period_in);
    if (adv) begin
      next_pos(int'(mode), L, m_step, m_dir, ns, nd, nb);
      m_step = ns;
      m_dir  = nd;
      e.cyc = cyc + 1; e.stp = ns; e.dr = nd; e.bar = nb;
      sbq.push_back(e);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented or expected tick against the queue.
  always @(negedge clk) begin
    if (poweron) begin
      bit exp_tick;
      exp_tick = (sbq.size() > 0) && (sbq[0].cyc == cyc);
      if (step_tick || exp_tick) begin
        chk("step_tick", int'(step_tick), int'(exp_tick));
        if (exp_tick) begin
          exp_t e;
          e = sbq.pop_front();
          if (step_tick) begin
            chk("step", int'(step), e.stp);
            chk("dir", int'(dir), e.dr);
            chk("bar_tick", int'(bar_tick), e.bar);
          end
        end
      end else if (bar_tick) begin
        chk("bar_without_step", int'(bar_tick), 0);
      end
    end
  end

  initial begin
    poweron = 0; run = 0; restart = 0; period_wr = 0;
    period_in = '0; loop_len = '0; mode = 2'd0;
    m_reset();
    cycle(); cycle();
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_step_tick", int'(step_tick), 0);
    chk("rst_bar_tick", int'(bar_tick), 0);
    poweron = 1;
    cycle();

    // First advance DEF_P clocks after run rises.
    loop_len = 4'd3; mode = 2'd0; run = 1;
    for (int k = 0; k < DEF_P - 1; k++) cycle();
    chk("first_adv_not_early", int'(step), 0);
    cycle();
    chk("first_adv_step", int'(step), 1);

    // Period 4, FWD, loop 3.
    run = 0; restart = 1; period_wr = 1; period_in = 8'd4;
    cycle();
    restart = 0; period_wr = 0; run = 1;
    repeat (20) cycle();

    // Ping-pong, loop 3, period 2.
    mode = 2'd2; restart = 1; period_wr = 1; period_in = 8'd2;
    cycle();
    restart = 0; period_wr = 0;
    repeat (18) cycle();

    // Loop shortened below current step mid-count.
    mode = 2'd0; loop_len = 4'd7; restart = 1; period_wr = 1; period_in = 8'd8;
    cycle();
    restart = 0; period_wr = 0;
    for (int k = 0; k < 100 && m_step != 5; k++) cycle();
    chk("reach_step5", int'(step), 5);
    cycle(); cycle();
    loop_len = 4'd2;
    repeat (12) cycle();

    // Period shrink below running count.
    loop_len = 4'd15; restart = 1; period_wr = 1; period_in = 8'd10;
    cycle();
    restart = 0; period_wr = 0;
    for (int k = 0; k < 20 && m_cnt != 7; k++) cycle();
    period_wr = 1; period_in = 8'd3;
    cycle();
    period_wr = 0;
    cycle();
    chk("shrink_adv_step", int'(step), 1);
    repeat (9) cycle();
    chk("shrink_period3_step", int'(step), 4);

    // Restart coincident with terminal in REV, then hold with run low.
    mode = 2'd1; loop_len = 4'd7; restart = 1; period_wr = 1; period_in = 8'd4;
    cycle();
    restart = 0; period_wr = 0;
    repeat (6) cycle();
    for (int k = 0; k < 10 && m_cnt != m_period - 1; k++) cycle();
    restart = 1;
    cycle();
    restart = 0;
    chk("restart_rev_step", int'(step), 7);
    chk("restart_no_tick", int'(step_tick), 0);
    run = 0;
    repeat (20) cycle();
    chk("frozen_step", int'(step), 7);
    run = 1;
    repeat (8) cycle();

    // Power-off mid-count while step 6 is showing.
    mode = 2'd0; loop_len = 4'd9; restart = 1; period_wr = 1; period_in = 8'd3;
    cycle();
    restart = 0; period_wr = 0;
    for (int k = 0; k < 100 && m_step != 6; k++) cycle();
    chk("pre_rst_step6", int'(step), 6);
    #1 poweron = 0;
    #1;
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_dir", int'(dir), 1);
    chk("async_rst_step_tick", int'(step_tick), 0);
    chk("async_rst_bar_tick", int'(bar_tick), 0);
    sbq.delete();
    m_reset();
    cycle();
    poweron = 1;
    repeat (12) cycle();

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      restart   = ($urandom_range(0, 39) == 0);
      period_wr = ($urandom_range(0, 24) == 0);
      period_in = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) loop_len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      cycle();
    end

    run = 0; restart = 0; period_wr = 0;
    repeat (4) cycle();
    chk("queue_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
